// File: rtl/bridgerx.sv
// Receive bridge: tracks STM-1 byte position from the frame pulse, supervises
// frame-pulse alignment and steers each byte to SOH, AU-4 pointer, VC-4 POH or TUG-3 sinks.
module bridgerx #(
  parameter int WID  = 8,
  parameter int RWID = 4,
  parameter int CWID = 7,
  parameter int SWID = 2
) (
  input  logic            clk19,
  input  logic            rst,
  input  logic            dvld,
  input  logic            fp,
  input  logic [WID-1:0]  datain,
  output logic [RWID-1:0] row,
  output logic [CWID-1:0] col,
  output logic [SWID-1:0] sts,
  output logic            stmen,
  output logic [WID-1:0]  stmdo,
  output logic            au4en,
  output logic [WID-1:0]  au4do,
  output logic            vc4en,
  output logic [WID-1:0]  vc4do,
  output logic            tug3en,
  output logic [WID-1:0]  tug3do,
  output logic            inframe,
  output logic [7:0]      fperr
);

  localparam logic [RWID-1:0] ROW_LAST = RWID'(8);
  localparam logic [CWID-1:0] COL_LAST = CWID'(89);
  localparam logic [SWID-1:0] STS_LAST = SWID'(2);

  logic [RWID-1:0] nxt_row_reg;
  logic [CWID-1:0] nxt_col_reg;
  logic [SWID-1:0] nxt_sts_reg;
  logic            synced_reg;

  logic [RWID-1:0] cur_row, inc_row;
  logic [CWID-1:0] cur_col, inc_col;
  logic [SWID-1:0] cur_sts, inc_sts;
  logic            nxt_zero;
  logic            err;

  assign nxt_zero = (nxt_row_reg == '0) && (nxt_col_reg == '0) && (nxt_sts_reg == '0);

  // A frame pulse forces the current byte to the frame origin.
  always_comb begin
    cur_row = fp ? '0 : nxt_row_reg;
    cur_col = fp ? '0 : nxt_col_reg;
    cur_sts = fp ? '0 : nxt_sts_reg;
  end

  always_comb begin
    inc_row = cur_row;
    inc_col = cur_col;
    inc_sts = cur_sts + SWID'(1);
    if (cur_sts == STS_LAST) begin
      inc_sts = '0;
      inc_col = cur_col + CWID'(1);
      if (cur_col == COL_LAST) begin
        inc_col = '0;
        inc_row = (cur_row == ROW_LAST) ? '0 : cur_row + RWID'(1);
      end
    end
  end

  // Until the first pulse after reset there is no reference, so nothing counts as an error.
  always_comb begin
    err = 1'b0;
    if (dvld && synced_reg) begin
      if (fp && !nxt_zero)
        err = 1'b1;
      else if (!fp && nxt_zero && inframe)
        err = 1'b1;
    end
  end

  always_ff @(posedge clk19 or posedge rst) begin
    if (rst) begin
      nxt_row_reg <= '0;
      nxt_col_reg <= '0;
      nxt_sts_reg <= '0;
      synced_reg  <= 1'b0;
      row         <= '0;
      col         <= '0;
      sts         <= '0;
      stmen       <= 1'b0;
      au4en       <= 1'b0;
      vc4en       <= 1'b0;
      tug3en      <= 1'b0;
      stmdo       <= '0;
      au4do       <= '0;
      vc4do       <= '0;
      tug3do      <= '0;
      inframe     <= 1'b0;
      fperr       <= '0;
    end else begin
      stmen  <= 1'b0;
      au4en  <= 1'b0;
      vc4en  <= 1'b0;
      tug3en <= 1'b0;
      if (dvld) begin
        nxt_row_reg <= inc_row;
        nxt_col_reg <= inc_col;
        nxt_sts_reg <= inc_sts;
        row         <= cur_row;
        col         <= cur_col;
        sts         <= cur_sts;
        stmdo       <= datain;
        au4do       <= datain;
        vc4do       <= datain;
        tug3do      <= datain;
        // Decode uses the alignment state held before this byte was checked.
        stmen  <= inframe && (cur_row != RWID'(3)) && (cur_col <= CWID'(2));
        au4en  <= inframe && (cur_row == RWID'(3)) && (cur_col <= CWID'(2));
        vc4en  <= inframe && (cur_col >= CWID'(3)) && (cur_col <= CWID'(5));
        tug3en <= inframe && (cur_col >= CWID'(6)) && (cur_sts == '0);
        if (fp) begin
          synced_reg <= 1'b1;
          inframe    <= synced_reg && nxt_zero;
        end else if (err) begin
          inframe <= 1'b0;
        end
        if (err && (fperr != 8'hff))
          fperr <= fperr + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bridgerx.sv
// Directed bench for bridgerx: alignment, misplaced/missing pulses, dvld gaps,
// asynchronous reset and error-counter saturation.
module tb_bridgerx;

  logic       clk19 = 1'b0;
  logic       rst = 1'b1;
  logic       dvld = 1'b0;
  logic       fp = 1'b0;
  logic [7:0] datain = 8'h00;
  logic [3:0] row;
  logic [6:0] col;
  logic [1:0] sts;
  logic       stmen, au4en, vc4en, tug3en;
  logic [7:0] stmdo, au4do, vc4do, tug3do;
  logic       inframe;
  logic [7:0] fperr;

  bridgerx #(.WID(8), .RWID(4), .CWID(7), .SWID(2)) dut (
    .clk19(clk19), .rst(rst), .dvld(dvld), .fp(fp), .datain(datain),
    .row(row), .col(col), .sts(sts),
    .stmen(stmen), .stmdo(stmdo), .au4en(au4en), .au4do(au4do),
    .vc4en(vc4en), .vc4do(vc4do), .tug3en(tug3en), .tug3do(tug3do),
    .inframe(inframe), .fperr(fperr)
  );

  always #5 clk19 = ~clk19;

  int n_chk = 0;
  int n_fail = 0;
  int n_stm, n_au4, n_vc4, n_tug, n_gap_en, n_multi;
  logic [7:0] data_ctr = 8'h00;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic clr_cnt();
    n_stm = 0; n_au4 = 0; n_vc4 = 0; n_tug = 0;
  endtask

  // One clock: drive inputs away from the edge, sample outputs 1 time unit after it.
  task automatic cyc(input logic v, input logic f);
    int nen;
    dvld = v;
    fp   = f;
    if (v) begin
      data_ctr  = data_ctr + 8'd1;
      datain    = data_ctr;
      last_data = data_ctr;
    end
    @(posedge clk19);
    #1;
    nen = int'(stmen) + int'(au4en) + int'(vc4en) + int'(tug3en);
    n_stm += int'(stmen);
    n_au4 += int'(au4en);
    n_vc4 += int'(vc4en);
    n_tug += int'(tug3en);
    if (nen > 1) n_multi++;
    if (!v && nen != 0) n_gap_en++;
  endtask

  task automatic run(input int n, input logic fp0, input logic gaps);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, fp0 && (i == 0));
      if (gaps) cyc(1'b0, 1'b0);
    end
  endtask

  task automatic check_cnt(input string tag, input int s, input int a, input int v, input int t);
    check({tag, "_stm"}, n_stm, s);
    check({tag, "_au4"}, n_au4, a);
    check({tag, "_vc4"}, n_vc4, v);
    check({tag, "_tug3"}, n_tug, t);
  endtask

  initial begin
    n_gap_en = 0;
    n_multi  = 0;
    clr_cnt();
    #23;
    check("rst_en", int'({stmen, au4en, vc4en, tug3en}), 0);
    check("rst_pos", int'({row, col, sts}), 0);
    check("rst_inframe", int'(inframe), 0);
    rst = 1'b0;
    #4;

    // Three clean frames: first pulse only realigns, second sets inframe.
    run(2430, 1'b1, 1'b0);
    check("f1_inframe", int'(inframe), 0);
    check("f1_nosink", n_stm + n_au4 + n_vc4 + n_tug, 0);
    clr_cnt();
    run(1, 1'b1, 1'b0);
    check("f2_inframe", int'(inframe), 1);
    run(2429, 1'b0, 1'b0);
    check_cnt("f2", 71, 9, 81, 756);
    clr_cnt();
    run(2430, 1'b1, 1'b0);
    check_cnt("f3", 72, 9, 81, 756);
    check("f3_pos", int'({row, col, sts}), int'({4'd8, 7'd89, 2'd2}));
    check("f3_tug3do", int'(tug3do), int'(last_data));
    check("f3_stmdo", int'(stmdo), int'(last_data));
    check("f3_fperr", int'(fperr), 0);

    // Misplaced pulse at byte 1000 of an aligned frame.
    run(1000, 1'b1, 1'b0);
    run(1, 1'b1, 1'b0);
    check("mis_inframe", int'(inframe), 0);
    check("mis_fperr", int'(fperr), 1);
    check("mis_pos", int'({row, col, sts}), 0);
    run(1, 1'b0, 1'b0);
    check("mis_next_pos", int'({row, col, sts}), int'({4'd0, 7'd0, 2'd1}));
    run(2428, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    check("mis_realign", int'(inframe), 1);
    check("mis_fperr2", int'(fperr), 1);
    run(2429, 1'b0, 1'b0);

    // Missing pulse at a frame boundary.
    run(1, 1'b0, 1'b0);
    check("miss_inframe", int'(inframe), 0);
    check("miss_fperr", int'(fperr), 2);
    check("miss_pos", int'({row, col, sts}), 0);
    clr_cnt();
    run(2429, 1'b0, 1'b0);
    check("miss_nosink", n_stm + n_au4 + n_vc4 + n_tug, 0);
    clr_cnt();
    run(2430, 1'b1, 1'b0);
    check("miss_realign", int'(inframe), 1);
    check_cnt("miss_f", 71, 9, 81, 756);

    // dvld toggling every cycle over two frames.
    clr_cnt();
    n_gap_en = 0;
    run(2430, 1'b1, 1'b1);
    run(2430, 1'b1, 1'b1);
    check_cnt("gap", 144, 18, 162, 1512);
    check("gap_en_after_idle", n_gap_en, 0);
    check("gap_hold_pos", int'({row, col, sts}), int'({4'd8, 7'd89, 2'd2}));
    check("gap_fperr", int'(fperr), 2);
    check("gap_inframe", int'(inframe), 1);

    // Asynchronous reset mid-frame (row 5).
    run(1400, 1'b1, 1'b0);
    check("pre_rst_row", int'(row), 5);
    #3 rst = 1'b1;
    #1;
    check("arst_en", int'({stmen, au4en, vc4en, tug3en}), 0);
    check("arst_do", int'({stmdo, au4do, vc4do, tug3do}), 0);
    check("arst_pos", int'({row, col, sts}), 0);
    check("arst_inframe", int'(inframe), 0);
    check("arst_fperr", int'(fperr), 0);
    dvld = 1'b0;
    fp   = 1'b0;
    #1 rst = 1'b0;
    run(100, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    check("post_rst_fperr", int'(fperr), 0);
    check("post_rst_inframe", int'(inframe), 0);
    run(2429, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    check("post_rst_lock", int'(inframe), 1);
    check("post_rst_fperr2", int'(fperr), 0);

    // 300 consecutive misplaced pulses saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      run(1, 1'b1, 1'b0);
      if (i == 253) check("sat_254", int'(fperr), 254);
    end
    check("sat_255", int'(fperr), 255);
    run(10, 1'b0, 1'b0);
    check("sat_hold", int'(fperr), 255);
    check("sat_inframe", int'(inframe), 0);

    check("exclusive_en", n_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
